rr_ring_arbiter: RTL and testbench



---
 rtl/rr_ring_arbiter.sv | 155 +++++++++++++++
 tb/tb_rr_ring_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter sharing one downstream resource
// between N requesters. Rotation priority lives in a one-hot ring pointer.
// A grant is registered and held until the owner drops its request.
//
// Optional build macro: RR_ARB_TIMEOUT_EN
//   defined   -> a grant held for HOLD_MAX cycles is revoked when another
//                requester is waiting
//   undefined -> no hold counter; a grant lasts until the owner releases it
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate req starting at the ptr index
// BUSY  | gnt_id owns the resource; watch for release (or revocation)
//
// Every release or revocation passes through IDLE, so there is always
// exactly one gnt=0 cycle between grants (bus turnaround).

module rr_ring_arbiter #(
    parameter  int N        = 4,
    parameter  int HOLD_MAX = 8,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   ptr
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   gnt_nxt;
    logic           gnt_valid_nxt;
    logic [IDW-1:0] gnt_id_nxt;
    logic [N-1:0]   ptr_nxt;

    logic [IDW-1:0] ptr_id;
    logic [IDW-1:0] sel_id;
    logic [N-1:0]   sel_oh;
    logic           owner_leaves;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_nxt;
`endif

    // Binary index of the ring pointer, used as the search start.
    always_comb begin
        ptr_id = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) begin
                ptr_id = IDW'(i);
            end
        end
    end

    // First set request at or above the ptr index, wrapping modulo N.
    always_comb begin
        int idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        sel_id = '0;
        sel_oh = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_id) + i) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                sel_id      = IDW'(idx);
                sel_oh[idx] = 1'b1;
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        gnt_valid_nxt = gnt_valid;
        gnt_id_nxt    = gnt_id;
        ptr_nxt       = ptr;
        owner_leaves  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hold_nxt      = hold_cnt;
`endif

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt       = sel_oh;
                    gnt_valid_nxt = 1'b1;
                    gnt_id_nxt    = sel_id;
                    state_nxt     = BUSY;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_nxt      = '0;
`endif
                end
            end
            BUSY: begin
                if (!req[gnt_id]) begin
                    owner_leaves = 1'b1;
                end
`ifdef RR_ARB_TIMEOUT_EN
                // Revoke only when someone else is actually waiting;
                // otherwise the counter just sits saturated.
                else if ((hold_cnt == HOLD_LAST) && |(req & ~gnt)) begin
                    owner_leaves = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + HCW'(1);
                end
`endif
                if (owner_leaves) begin
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = {gnt[N-2:0], gnt[N-1]};
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= {{(N-1){1'b0}}, 1'b1};
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_valid <= gnt_valid_nxt;
            gnt_id    <= gnt_id_nxt;
            ptr       <= ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench for rr_ring_arbiter: a cycle model predicts the registered
// outputs when each stimulus cycle is driven, the prediction is queued,
// and it is popped and compared one edge later. A few directed
// constant checks pin down the plan's named scenarios.

module tb_rr_ring_arbiter;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;
    localparam int IDW      = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   ptr;

    typedef struct packed {
        logic [N-1:0]   gnt;
        logic           gnt_valid;
        logic [IDW-1:0] gnt_id;
        logic [N-1:0]   ptr;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    // model state
    int m_busy  = 0;
    int m_owner = 0;
    int m_gid   = 0;
    int m_ptr   = 0;
    int m_hold  = 0;

    rr_ring_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one edge given the inputs sampled at it.
    task automatic model_edge(input logic r, input logic [N-1:0] rq);
        logic [N-1:0] others;
        if (r) begin
            m_busy = 0; m_gid = 0; m_ptr = 0; m_hold = 0;
        end else if (m_busy == 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (m_busy == 0 && rq[k]) begin
                    m_busy = 1; m_owner = k; m_gid = k; m_hold = 0;
                end
            end
        end else if (!rq[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else begin
            others = rq;
            others[m_owner] = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            if (m_hold == HOLD_MAX - 1 && others != '0) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else if (m_hold < HOLD_MAX - 1) begin
                m_hold++;
            end
`else
            if (others != '0) m_hold = 0;
`endif
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt             = '0;
        if (m_busy != 0) e.gnt[m_owner] = 1'b1;
        e.gnt_valid       = (m_busy != 0);
        e.gnt_id          = IDW'(m_gid);
        e.ptr             = '0;
        e.ptr[m_ptr]      = 1'b1;
        return e;
    endfunction

    // One clock: drive, predict, push; then pop and compare after the edge.
    task automatic step(input logic r, input logic [N-1:0] rq);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        model_edge(r, rq);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_gnt",   32'(gnt),       32'(e.gnt));
            chk("sb_valid", 32'(gnt_valid), 32'(e.gnt_valid));
            chk("sb_id",    32'(gnt_id),    32'(e.gnt_id));
            chk("sb_ptr",   32'(ptr),       32'(e.ptr));
        end
    endtask

    int           exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_ptr[5]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [N-1:0] one          = 4'b0001;

    initial begin
        int run;
        int ended;

        // reset with all requests up
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_id",    32'(gnt_id),    32'h0);
        chk("rst_ptr",   32'(ptr),       32'h1);

        // single requester
        step(1'b0, 4'b0100);
        chk("single_gnt", 32'(gnt),    32'b0100);
        chk("single_id",  32'(gnt_id), 32'd2);
        repeat (3) step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_ptr", 32'(ptr), 32'b1000);

        // full rotation from ptr=0001
        step(1'b1, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111);
            chk("rot_id",  32'(gnt_id), 32'(exp_order[k]));
            chk("rot_gnt", 32'(gnt),    32'(one << exp_order[k]));
            repeat (2) step(1'b0, 4'b1111);
            step(1'b0, 4'b1111 & ~(one << exp_order[k]));
            chk("rot_gap", 32'(gnt), 32'h0);
            chk("rot_ptr", 32'(ptr), 32'(exp_ptr[k]));
        end

        // priority from ptr=1000
        step(1'b0, 4'b0100);
        step(1'b0, 4'b0000);
        chk("prio_ptr0", 32'(ptr), 32'b1000);
        step(1'b0, 4'b0110);
        chk("prio_gnt", 32'(gnt), 32'b0010);
        step(1'b0, 4'b0100);
        chk("prio_ptr", 32'(ptr), 32'b0100);
        step(1'b0, 4'b0000);

        // reset mid-grant
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        chk("mid_gnt", 32'(gnt), 32'b0010);
        step(1'b1, 4'b0010);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_ptr", 32'(ptr), 32'h1);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);

        // hold limit with two contenders
        step(1'b1, 4'b0000);
        run = 0;
        ended = 0;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, 4'b0011);
            if (ended == 0) begin
                if (gnt == 4'b0001) run++;
                else if (run > 0) ended = 1;
            end
        end
`ifdef RR_ARB_TIMEOUT_EN
        chk("hold_len", 32'(run), 32'(HOLD_MAX));
`else
        chk("hold_long", 32'(run >= 20), 32'd1);
`endif
        step(1'b0, 4'b0000);

        // random traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
